// File: rtl/controlador_interrupciones_if.sv
// Request/acknowledge bundle between the interrupt controller and the CPU.
// The master side drives the raw request lines, mask, ack and eoi. The controller is the slave side.
interface controlador_interrupciones_if #(parameter int N_IR = 4);
   logic [N_IR-1:0] ir_in;
   logic [N_IR-1:0] mask;
   logic            ack;
   logic            eoi;
   logic            irq;
   logic [2:0]      ir_vector;
   logic [N_IR-1:0] pending;
   logic            in_service;

   modport master (
      output ir_in, mask, ack, eoi,
      input  irq, ir_vector, pending, in_service
   );

   modport slave (
      input  ir_in, mask, ack, eoi,
      output irq, ir_vector, pending, in_service
   );
endinterface

// File: rtl/controlador_interrupciones.sv
// Non-nesting interrupt controller: sync + edge detect, pending latch, fixed priority (index 0 highest).
// An input edge becomes pending 3 edges after the input rises and raises irq 1 edge later; ack/eoi sequence the service.
module controlador_interrupciones #(
   parameter int N_IR = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   controlador_interrupciones_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t          r_state;
   logic [N_IR-1:0] r_q1;
   logic [N_IR-1:0] r_q2;
   logic [N_IR-1:0] r_prv;
   logic [N_IR-1:0] r_pending;
   logic            r_irq;
   logic            r_in_service;
   logic [2:0]      r_vec;

   logic [N_IR-1:0] w_rise;
   logic [N_IR-1:0] w_cand;
   logic [N_IR-1:0] w_clr;
   logic [2:0]      w_win;

   assign w_rise = r_q2 & ~r_prv;
   assign w_cand = r_pending & bus.mask;

   always_comb begin
      w_win = 3'd0;
      w_clr = '0;
      // Scanning downwards lets the lowest-index candidate overwrite the others.
      for (int i = N_IR - 1; i >= 0; i--) begin
         if (w_cand[i]) w_win = 3'(i + 1);
      end
      for (int i = 0; i < N_IR; i++) begin
         if (r_state == REQ && bus.ack && r_vec == 3'(i + 1)) w_clr[i] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q1      <= '0;
         r_q2      <= '0;
         r_prv     <= '0;
         r_pending <= '0;
      end else begin
         r_q1      <= bus.ir_in;
         r_q2      <= r_q1;
         r_prv     <= r_q2;
         r_pending <= w_rise | (r_pending & ~w_clr);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_irq        <= 1'b0;
         r_vec        <= 3'd0;
         r_in_service <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_win != 3'd0) begin
                  r_state <= REQ;
                  r_irq   <= 1'b1;
                  r_vec   <= w_win;
               end
            end
            REQ: begin
               // The latched vector is held until ack, whatever mask or new arrivals do.
               if (bus.ack) begin
                  r_state      <= SERVICE;
                  r_irq        <= 1'b0;
                  r_in_service <= 1'b1;
               end
            end
            SERVICE: begin
               if (bus.eoi) begin
                  r_state      <= IDLE;
                  r_in_service <= 1'b0;
                  r_vec        <= 3'd0;
               end
            end
            default: begin
               r_state      <= IDLE;
               r_irq        <= 1'b0;
               r_vec        <= 3'd0;
               r_in_service <= 1'b0;
            end
         endcase
      end
   end

   assign bus.irq        = r_irq;
   assign bus.ir_vector  = r_vec;
   assign bus.pending    = r_pending;
   assign bus.in_service = r_in_service;
endmodule

// File: tb/tb_controlador_interrupciones.sv
// Directed bench for controlador_interrupciones: reset, single source, priority, mask, coalescing, set-wins, mid-run reset.
module tb_controlador_interrupciones;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;
   int   cnt;

   controlador_interrupciones_if #(.N_IR(4)) bus();

   controlador_interrupciones #(.N_IR(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_ack();
      bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
   endtask

   task automatic pulse_eoi();
      bus.eoi = 1'b1;
      tick();
      bus.eoi = 1'b0;
   endtask

   task automatic tickn(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b0;
      bus.ir_in = 4'b0000;
      bus.mask  = 4'b1111;
      bus.ack   = 1'b0;
      bus.eoi   = 1'b0;

      // 1. Asynchronous reset, checked before any clock edge
      #2 reset = 1'b1;
      #1;
      chk("rst_irq", 8'(bus.irq), 8'd0);
      chk("rst_vec", 8'(bus.ir_vector), 8'd0);
      chk("rst_pending", 8'(bus.pending), 8'd0);
      chk("rst_insvc", 8'(bus.in_service), 8'd0);
      tickn(2);
      reset = 1'b0;
      tickn(2);
      chk("idle_irq", 8'(bus.irq), 8'd0);

      // 2. Single source 2 -> vector 3
      bus.ir_in = 4'b0100;
      tickn(3);
      chk("s2_pending", 8'(bus.pending), 8'h04);
      chk("s2_irq_early", 8'(bus.irq), 8'd0);
      tick();
      chk("s2_irq", 8'(bus.irq), 8'd1);
      chk("s2_vec", 8'(bus.ir_vector), 8'd3);
      pulse_ack();
      chk("s2_ack_irq", 8'(bus.irq), 8'd0);
      chk("s2_ack_insvc", 8'(bus.in_service), 8'd1);
      chk("s2_ack_pending", 8'(bus.pending), 8'd0);
      chk("s2_ack_vec", 8'(bus.ir_vector), 8'd3);
      bus.ir_in = 4'b0000;
      tickn(3);
      pulse_eoi();
      chk("s2_eoi_insvc", 8'(bus.in_service), 8'd0);
      chk("s2_eoi_vec", 8'(bus.ir_vector), 8'd0);
      tick();
      chk("s2_quiet", 8'(bus.irq), 8'd0);

      // 3. Priority: sources 1 and 3 together
      bus.ir_in = 4'b1010;
      tickn(3);
      chk("pri_pending", 8'(bus.pending), 8'h0A);
      tick();
      chk("pri_irq1", 8'(bus.irq), 8'd1);
      chk("pri_vec1", 8'(bus.ir_vector), 8'd2);
      pulse_ack();
      chk("pri_pending_ack", 8'(bus.pending), 8'h08);
      bus.ir_in = 4'b0000;
      pulse_eoi();
      chk("pri_gap_irq", 8'(bus.irq), 8'd0);
      tick();
      chk("pri_irq2", 8'(bus.irq), 8'd1);
      chk("pri_vec2", 8'(bus.ir_vector), 8'd4);
      pulse_ack();
      pulse_eoi();
      chk("pri_done_pending", 8'(bus.pending), 8'd0);

      // 4. Masking of source 0
      bus.mask  = 4'b1110;
      bus.ir_in = 4'b0001;
      tick();
      bus.ir_in = 4'b0000;
      tickn(2);
      chk("msk_pending", 8'(bus.pending), 8'h01);
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (bus.irq !== 1'b0) cnt++;
      end
      chk("msk_irq_held", 8'(cnt), 8'd0);
      chk("msk_pending_held", 8'(bus.pending), 8'h01);
      bus.mask = 4'b1111;
      tick();
      chk("msk_irq", 8'(bus.irq), 8'd1);
      chk("msk_vec", 8'(bus.ir_vector), 8'd1);
      pulse_ack();
      pulse_eoi();

      // 5a. Coalescing: three edges on source 1 while source 2 is in service
      bus.ir_in = 4'b0100;
      tick();
      bus.ir_in = 4'b0000;
      tickn(3);
      chk("coa_vec_svc", 8'(bus.ir_vector), 8'd3);
      pulse_ack();
      for (int k = 0; k < 3; k++) begin
         bus.ir_in = 4'b0010;
         tickn(2);
         bus.ir_in = 4'b0000;
         tickn(2);
      end
      tickn(3);
      chk("coa_pending", 8'(bus.pending), 8'h02);
      chk("coa_insvc", 8'(bus.in_service), 8'd1);
      pulse_eoi();
      tick();
      chk("coa_irq", 8'(bus.irq), 8'd1);
      chk("coa_vec", 8'(bus.ir_vector), 8'd2);
      pulse_ack();
      pulse_eoi();
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (bus.irq !== 1'b0) cnt++;
      end
      chk("coa_only_one", 8'(cnt), 8'd0);

      // 5b. New edge detected on the same edge as its ack: set wins
      bus.ir_in = 4'b0010;
      tick();
      bus.ir_in = 4'b0000;
      tickn(3);
      chk("sw_vec", 8'(bus.ir_vector), 8'd2);
      bus.ir_in = 4'b0010;
      tickn(2);
      bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
      chk("sw_pending", 8'(bus.pending), 8'h02);
      chk("sw_insvc", 8'(bus.in_service), 8'd1);
      bus.ir_in = 4'b0000;
      pulse_eoi();
      tick();
      chk("sw_reirq", 8'(bus.irq), 8'd1);
      chk("sw_revec", 8'(bus.ir_vector), 8'd2);
      pulse_ack();
      pulse_eoi();

      // 6. Reset while in REQ with vector 2
      bus.ir_in = 4'b0010;
      tick();
      bus.ir_in = 4'b0000;
      tickn(3);
      chk("mr_irq_pre", 8'(bus.irq), 8'd1);
      chk("mr_vec_pre", 8'(bus.ir_vector), 8'd2);
      #2 reset = 1'b1;
      #1;
      chk("mr_irq", 8'(bus.irq), 8'd0);
      chk("mr_vec", 8'(bus.ir_vector), 8'd0);
      chk("mr_pending", 8'(bus.pending), 8'd0);
      chk("mr_insvc", 8'(bus.in_service), 8'd0);
      tick();
      reset = 1'b0;
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (bus.irq !== 1'b0) cnt++;
      end
      chk("mr_quiet", 8'(cnt), 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
